// File: rtl/klein_80_dec_pkg.sv
// Shared KLEIN-80 definitions: sizes, FSM encoding, 4-bit S-box and GF(2^8) helpers.
// The serial encryptor uses the same S-box and GF helpers.
package klein_80_dec_pkg;

  localparam int NR     = 16;
  localparam int KBYTES = 10;
  localparam int SBYTES = 8;
  localparam int KEY_W  = 8 * KBYTES;
  localparam int BLK_W  = 8 * SBYTES;

  // S[0] in the top nibble, S[15] in the bottom nibble; the S-box is an involution
  localparam logic [63:0] SBOX_TBL = 64'h74A91FB0C3268ED5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KFWD,
    ST_WHITEN,
    ST_DEC,
    ST_OUT
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[63 - 4*int'(x) -: 4];
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return {sbox(b[7:4]), sbox(b[3:0])};
  endfunction

  function automatic logic [BLK_W-1:0] sub_block(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int n = 0; n < 2*SBYTES; n++) r[4*n +: 4] = sbox(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // AES InvMixColumns on one 4-byte column, byte 0 in the top bits
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] c0, c1, c2, c3;
    c0 = c[31:24];
    c1 = c[23:16];
    c2 = c[15:8];
    c3 = c[7:0];
    return {gf_mul(c0, 8'h0E) ^ gf_mul(c1, 8'h0B) ^ gf_mul(c2, 8'h0D) ^ gf_mul(c3, 8'h09),
            gf_mul(c0, 8'h09) ^ gf_mul(c1, 8'h0E) ^ gf_mul(c2, 8'h0B) ^ gf_mul(c3, 8'h0D),
            gf_mul(c0, 8'h0D) ^ gf_mul(c1, 8'h09) ^ gf_mul(c2, 8'h0E) ^ gf_mul(c3, 8'h0B),
            gf_mul(c0, 8'h0B) ^ gf_mul(c1, 8'h0D) ^ gf_mul(c2, 8'h09) ^ gf_mul(c3, 8'h0E)};
  endfunction

endpackage

// File: rtl/klein_80_dec_if.sv
// Byte-serial start/ready bus of the KLEIN-80 decryptor.
interface klein_80_dec_if;
  logic       start;
  logic [7:0] inp;
  logic [7:0] key;
  logic       ready;
  logic [7:0] out;

  modport master (output start, inp, key, input ready, out);
  modport slave  (input start, inp, key, output ready, out);
endinterface

// File: rtl/klein_80_dec_ks_unit.sv
// One combinational KLEIN-80 key-schedule step: dir=0 computes K(i+1) from K(i),
// dir=1 computes K(i) from K(i+1). Key byte 0 sits in the top bits.
module klein_ks_unit
  import klein_80_dec_pkg::*;
(
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_dir,
  input  logic [4:0]       i_rnd,
  output logic [KEY_W-1:0] o_key
);

  logic [39:0]      w_rc_mask;
  logic [39:0]      w_fa;
  logic [39:0]      w_fb;
  logic [39:0]      w_fx;
  logic [KEY_W-1:0] w_fwd;
  logic [39:0]      w_ia;
  logic [39:0]      w_ib;
  logic [39:0]      w_ar;
  logic [KEY_W-1:0] w_inv;

  // round constant lands on byte 2 of the left half
  assign w_rc_mask = {16'h0000, 3'b000, i_rnd, 16'h0000};

  assign w_fa  = {i_key[71:40], i_key[79:72]};
  assign w_fb  = {i_key[31:0], i_key[39:32]};
  assign w_fx  = w_fa ^ w_fb;
  assign w_fwd = {w_fb ^ w_rc_mask,
                  w_fx[39:32], sub_byte(w_fx[31:24]), sub_byte(w_fx[23:16]), w_fx[15:0]};

  // undo the S-box and round constant, then the Feistel swap and the byte rotations
  assign w_ia  = i_key[79:40] ^ w_rc_mask;
  assign w_ib  = {i_key[39:32], sub_byte(i_key[31:24]), sub_byte(i_key[23:16]), i_key[15:0]};
  assign w_ar  = w_ib ^ w_ia;
  assign w_inv = {w_ar[7:0], w_ar[39:8], w_ia[7:0], w_ia[39:8]};

  assign o_key = i_dir ? w_inv : w_fwd;

endmodule

// File: rtl/klein_80_dec.sv
// Byte-serial iterative KLEIN-80 decryptor: loads ciphertext and key, runs the key
// schedule forward to K17, then decrypts one round per cycle while rewinding it.
module klein_80_dec
  import klein_80_dec_pkg::*;
(
  input  logic          ck,
  input  logic          rst,
  klein_80_dec_if.slave bus
);

  fsm_e             r_fsm;
  logic [3:0]       r_bcnt;
  logic [4:0]       r_rnd;
  logic [BLK_W-1:0] r_state;
  logic [KEY_W-1:0] r_key;
  logic             r_ready;
  logic [7:0]       r_out;

  logic             w_dir;
  logic [KEY_W-1:0] w_ks_key;
  logic [BLK_W-1:0] w_imix;
  logic [BLK_W-1:0] w_rot;
  logic [BLK_W-1:0] w_round;

  assign w_dir = (r_fsm == ST_DEC);

  klein_ks_unit u_ks (
    .i_key (r_key),
    .i_dir (w_dir),
    .i_rnd (r_rnd),
    .o_key (w_ks_key)
  );

  // inverse round: InvMixNibbles, rotate right two bytes, S-box, add K(i)
  assign w_imix  = {inv_mix_col(r_state[63:32]), inv_mix_col(r_state[31:0])};
  assign w_rot   = {w_imix[15:0], w_imix[63:16]};
  assign w_round = sub_block(w_rot) ^ w_ks_key[KEY_W-1 -: BLK_W];

  always_ff @(posedge ck) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_bcnt  <= '0;
      r_rnd   <= '0;
      r_state <= '0;
      r_key   <= '0;
      r_ready <= 1'b0;
      r_out   <= '0;
    end else begin
      r_ready <= 1'b0;
      r_out   <= '0;
      case (r_fsm)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= {56'h0, bus.inp};
            r_key   <= {72'h0, bus.key};
            r_bcnt  <= 4'd1;
            r_fsm   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_bcnt < 4'd8) r_state <= {r_state[55:0], bus.inp};
          r_key <= {r_key[71:0], bus.key};
          if (r_bcnt == 4'd9) begin
            r_bcnt <= '0;
            r_rnd  <= 5'd1;
            r_fsm  <= ST_KFWD;
          end else begin
            r_bcnt <= r_bcnt + 4'd1;
          end
        end
        ST_KFWD: begin
          r_key <= w_ks_key;
          if (r_rnd == 5'(NR)) r_fsm <= ST_WHITEN;
          else                 r_rnd <= r_rnd + 5'd1;
        end
        ST_WHITEN: begin
          r_state <= r_state ^ r_key[KEY_W-1 -: BLK_W];
          r_rnd   <= 5'(NR);
          r_fsm   <= ST_DEC;
        end
        ST_DEC: begin
          r_state <= w_round;
          r_key   <= w_ks_key;
          if (r_rnd == 5'd1) begin
            // byte 0 leaves with the last round so ready rises as OUT begins
            r_ready <= 1'b1;
            r_out   <= w_round[63:56];
            r_bcnt  <= 4'd1;
            r_fsm   <= ST_OUT;
          end else begin
            r_rnd <= r_rnd - 5'd1;
          end
        end
        ST_OUT: begin
          if (r_bcnt == 4'd8) begin
            r_bcnt <= '0;
            r_fsm  <= ST_IDLE;
          end else begin
            r_ready <= 1'b1;
            r_out   <= r_state[55:48];
            r_state <= {r_state[55:0], 8'h00};
            r_bcnt  <= r_bcnt + 4'd1;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.out   = r_out;

endmodule

// File: tb/tb_klein_80_dec.sv
// Scoreboard bench for klein_80_dec: a driver queues expected plaintexts and start
// cycles, a monitor assembles each 8-byte ready frame and compares.
module tb_klein_80_dec;

  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  klein_80_dec_if bus();

  klein_80_dec dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  int          st_q[$];

  localparam logic [63:0] VA_CT = 64'h6677E20D1A53A431;
  localparam logic [79:0] VA_K  = 80'h0;
  localparam logic [63:0] VA_PT = 64'hFFFFFFFFFFFFFFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // ---------------- reference encryptor ----------------
  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [3:0] t [16];
    t = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
          4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};
    return t[x];
  endfunction

  function automatic logic [7:0] m_sub(input logic [7:0] b);
    return {m_sbox(b[7:4]), m_sbox(b[3:0])};
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] m_mix(input logic [31:0] c);
    logic [7:0] v [4];
    for (int n = 0; n < 4; n++) v[n] = c[31-8*n -: 8];
    return {m_gmul(v[0], 8'h02) ^ m_gmul(v[1], 8'h03) ^ v[2] ^ v[3],
            v[0] ^ m_gmul(v[1], 8'h02) ^ m_gmul(v[2], 8'h03) ^ v[3],
            v[0] ^ v[1] ^ m_gmul(v[2], 8'h02) ^ m_gmul(v[3], 8'h03),
            m_gmul(v[0], 8'h03) ^ v[1] ^ v[2] ^ m_gmul(v[3], 8'h02)};
  endfunction

  function automatic logic [79:0] m_ks(input logic [79:0] k, input int i);
    logic [7:0] kb [10];
    logic [7:0] na [5];
    logic [7:0] nb [5];
    logic [79:0] r;
    for (int j = 0; j < 10; j++) kb[j] = k[79-8*j -: 8];
    for (int j = 0; j < 5; j++) begin
      na[j] = kb[5 + (j+1) % 5];
      nb[j] = kb[(j+1) % 5] ^ kb[5 + (j+1) % 5];
    end
    na[2] ^= 8'(i);
    nb[1] = m_sub(nb[1]);
    nb[2] = m_sub(nb[2]);
    r = '0;
    for (int j = 0; j < 5; j++) begin
      r[79-8*j -: 8] = na[j];
      r[39-8*j -: 8] = nb[j];
    end
    return r;
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int i = 1; i <= 16; i++) begin
      s ^= k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = m_sbox(s[4*n +: 4]);
      s = {s[47:0], s[63:48]};
      s = {m_mix(s[63:32]), m_mix(s[31:0])};
      k = m_ks(k, i);
    end
    return s ^ k[79:16];
  endfunction

  // ---------------- driver ----------------
  // mode 0: single start pulse; 1: extra start pulses in LOAD/KFWD/DEC/OUT; 2: start held high
  task automatic run_op(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] pt,
                        input int mode, input int ncyc, input bit expect_out);
    if (expect_out) begin
      exp_q.push_back(pt);
      st_q.push_back(cyc);
    end
    for (int c = 0; c < ncyc; c++) begin
      bus.start = (c == 0) || (mode == 2) ||
                  (mode == 1 && (c == 3 || c == 15 || c == 35 || c == 45 || c == 50));
      bus.inp = (c < 8)  ? ct[63-8*c -: 8] : 8'hC3;
      bus.key = (c < 10) ? k[79-8*c -: 8]  : 8'h5A;
      @(posedge ck); #1;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int          idx;
    int          st;
    logic [63:0] got;
    logic [63:0] e;
    idx = 0;
    got = '0;
    forever begin
      @(negedge ck);
      if (bus.ready === 1'b1) begin
        if (idx == 0) begin
          if (st_q.size() == 0) chk("unexpected_frame", 64'(cyc), 64'hFFFF_FFFF);
          else begin
            st = st_q.pop_front();
            chk("latency", 64'(cyc - st), 64'd43);
          end
        end
        got = {got[55:0], bus.out};
        idx++;
        if (idx == 8) begin
          if (exp_q.size() == 0) chk("no_expected", got, 64'hx);
          else begin
            e = exp_q.pop_front();
            chk("plaintext", got, e);
          end
          idx = 0;
        end
      end else begin
        chk("out_idle_zero", 64'(bus.out), 64'h0);
        if (idx != 0) begin
          chk("ready_short", 64'(idx), 64'd8);
          idx = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ct;
    logic [63:0] pt;
    logic [79:0] k;
    bus.start = 1'b0;
    bus.inp   = 8'h00;
    bus.key   = 8'h00;
    rst       = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    chk("reset_ready", 64'(bus.ready), 64'h0);
    chk("reset_out", 64'(bus.out), 64'h0);
    rst = 1'b0;
    @(posedge ck); #1;

    run_op(VA_CT, VA_K, VA_PT, 0, 51, 1);
    ct = m_encrypt(64'h0, {80{1'b1}});
    run_op(ct, {80{1'b1}}, 64'h0, 0, 51, 1);
    run_op(VA_CT, VA_K, VA_PT, 1, 51, 1);

    // abort in DEC round 9, then a fresh Vector A
    run_op(VA_CT, VA_K, VA_PT, 0, 34, 0);
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge ck); #1;
    chk("abort_ready", 64'(bus.ready), 64'h0);
    chk("abort_out", 64'(bus.out), 64'h0);
    rst = 1'b0;
    run_op(VA_CT, VA_K, VA_PT, 0, 51, 1);

    // start held high: one operation every 51 cycles
    run_op(VA_CT, VA_K, VA_PT, 2, 51, 1);
    run_op(ct, {80{1'b1}}, 64'h0, 2, 51, 1);
    pt = {$urandom, $urandom};
    k  = {16'($urandom), $urandom, $urandom};
    run_op(m_encrypt(pt, k), k, pt, 2, 51, 1);

    for (int n = 0; n < 200; n++) begin
      pt = {$urandom, $urandom};
      k  = {16'($urandom), $urandom, $urandom};
      run_op(m_encrypt(pt, k), k, pt, 0, 51, 1);
    end

    bus.start = 1'b0;
    repeat (60) @(posedge ck);
    #1;
    chk("drain_expected", 64'(exp_q.size()), 64'h0);
    chk("drain_starts", 64'(st_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
